// File: rtl/h3_matrix_regenerator.sv
// rtl/h3_matrix_regenerator.sv - H3 hash matrix regenerator: Galois LFSR rows into a shadow bank, atomic swap to active
module h3_matrix_regenerator #(
   parameter int                    NUMBER_OF_TABLES = 4,
   parameter int                    HASH_ADR_WIDTH   = 5,
   parameter int                    KEY_WIDTH        = 2,
   parameter int                    LFSR_WIDTH       = 32,
   parameter logic [LFSR_WIDTH-1:0] TAPS             = 32'h8020_0003,
   parameter logic [LFSR_WIDTH-1:0] SEED             = 32'h0000_0001,
   parameter bit                    REJECT_ZERO_ROWS = 1'b1,
   parameter bit                    AUTO_COMMIT      = 1'b1
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 regen_i,
   input  logic                                                 commit_i,
   input  logic                                                 seed_load_i,
   input  logic [LFSR_WIDTH-1:0]                                seed_i,
   output logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] matrixes_o,
   output logic                                                 valid_o,
   output logic                                                 busy_o,
   output logic                                                 pending_o,
   output logic                                                 done_o
);

   localparam int MW    = NUMBER_OF_TABLES * HASH_ADR_WIDTH * KEY_WIDTH;
   localparam int ROW_W = (HASH_ADR_WIDTH > 1) ? $clog2(HASH_ADR_WIDTH) : 1;
   localparam int TAB_W = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HASH_ADR_WIDTH - 1);
   localparam logic [TAB_W-1:0] TAB_LAST = TAB_W'(NUMBER_OF_TABLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GEN     = 2'd1,
      S_PENDING = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [LFSR_WIDTH-1:0]   lfsr;
   logic [LFSR_WIDTH-1:0]   lfsr_adv;
   logic [LFSR_WIDTH-1:0]   seed_eff;
   logic [KEY_WIDTH-1:0]    cand;
   logic [MW-1:0]           shadow;
   logic [MW-1:0]           shadow_next;
   logic [ROW_W-1:0]        row_cnt;
   logic [TAB_W-1:0]        tab_cnt;
   logic                    init_run;
   logic                    in_gen;
   logic                    accept;
   logic                    last_row;
   logic                    row_write;
   logic                    swap_gen;
   logic                    swap_commit;
   logic                    seed_take;
   logic                    clear_cnt;

   // KEY_WIDTH chained Galois steps per cycle; candidate bit k is the output bit of step k
   always_comb begin
      lfsr_adv = lfsr;
      cand     = '0;
      for (int k = 0; k < KEY_WIDTH; k++) begin
         cand[k]  = lfsr_adv[0];
         lfsr_adv = (lfsr_adv >> 1) ^ (lfsr_adv[0] ? TAPS : '0);
      end
   end

   // Shadow bank with the current candidate placed at the addressed row
   always_comb begin
      shadow_next = shadow;
      for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
         for (int r = 0; r < HASH_ADR_WIDTH; r++) begin
            if (tab_cnt == TAB_W'(t) && row_cnt == ROW_W'(r)) begin
               shadow_next[(t*HASH_ADR_WIDTH + r)*KEY_WIDTH +: KEY_WIDTH] = cand;
            end
         end
      end
   end

   assign seed_eff    = (seed_i == '0) ? SEED : seed_i;
   assign in_gen      = (state == S_GEN);
   assign accept      = !(REJECT_ZERO_ROWS && (cand == '0));
   assign last_row    = (tab_cnt == TAB_LAST) && (row_cnt == ROW_LAST);
   assign row_write   = in_gen && accept;
   // The post-reset run always publishes its result, even in manual-commit mode
   assign swap_gen    = row_write && last_row && (AUTO_COMMIT || init_run);
   // A simultaneous regen request wins over commit
   assign swap_commit = (state == S_PENDING) && commit_i && !regen_i;
   assign seed_take   = !in_gen && seed_load_i;
   assign clear_cnt   = !in_gen && regen_i;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_GEN;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (regen_i) state_next = S_GEN;
         end
         S_GEN: begin
            if (row_write && last_row) state_next = (AUTO_COMMIT || init_run) ? S_IDLE : S_PENDING;
         end
         S_PENDING: begin
            if (regen_i)       state_next = S_GEN;
            else if (commit_i) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State-decoded status outputs
   always_comb begin
      busy_o    = (state == S_GEN);
      pending_o = (state == S_PENDING);
   end

   // LFSR advances only while generating; seeds are taken only outside generation
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          lfsr <= SEED;
      else if (in_gen)    lfsr <= lfsr_adv;
      else if (seed_take) lfsr <= seed_eff;
   end

   // Row/table counters step on accepted rows, rows inner and tables outer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_cnt <= '0;
         tab_cnt <= '0;
      end else if (clear_cnt) begin
         row_cnt <= '0;
         tab_cnt <= '0;
      end else if (row_write) begin
         if (row_cnt == ROW_LAST) begin
            row_cnt <= '0;
            tab_cnt <= (tab_cnt == TAB_LAST) ? '0 : tab_cnt + TAB_W'(1);
         end else begin
            row_cnt <= row_cnt + ROW_W'(1);
         end
      end
   end

   // Shadow bank capture of accepted rows
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          shadow <= '0;
      else if (row_write) shadow <= shadow_next;
   end

   // Marks the automatic run after reset until its last row lands
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      init_run <= 1'b1;
      else if (row_write && last_row) init_run <= 1'b0;
   end

   // Active bank: changes only on a swap edge, with a one-cycle done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         matrixes_o <= '0;
         valid_o    <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         done_o <= swap_gen || swap_commit;
         if (swap_gen) begin
            matrixes_o <= shadow_next;
            valid_o    <= 1'b1;
         end else if (swap_commit) begin
            matrixes_o <= shadow;
            valid_o    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_h3_matrix_regenerator.sv
// tb/tb_h3_matrix_regenerator.sv - directed table-driven bench for h3_matrix_regenerator
module tb_h3_matrix_regenerator;

   localparam logic [31:0] TAPS_M = 32'h8020_0003;
   localparam logic [31:0] SEED_M = 32'h0000_0001;

   typedef struct {
      int          d;
      bit          load;
      logic [31:0] seed;
      bit          use_lo;
      logic [3:0]  lo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst    [3];
   logic        regen  [3];
   logic        commit [3];
   logic        sload  [3];
   logic [31:0] seed   [3];
   logic [39:0] mat    [3];
   logic        valid  [3];
   logic        busy   [3];
   logic        pend   [3];
   logic        done   [3];

   int n_cmp;
   int n_bad;

   always #5 clk = ~clk;

   h3_matrix_regenerator #(.REJECT_ZERO_ROWS(1'b0), .AUTO_COMMIT(1'b1)) u_a (
      .clk(clk), .reset(rst[0]), .regen_i(regen[0]), .commit_i(commit[0]),
      .seed_load_i(sload[0]), .seed_i(seed[0]), .matrixes_o(mat[0]),
      .valid_o(valid[0]), .busy_o(busy[0]), .pending_o(pend[0]), .done_o(done[0]));

   h3_matrix_regenerator #(.REJECT_ZERO_ROWS(1'b1), .AUTO_COMMIT(1'b1)) u_b (
      .clk(clk), .reset(rst[1]), .regen_i(regen[1]), .commit_i(commit[1]),
      .seed_load_i(sload[1]), .seed_i(seed[1]), .matrixes_o(mat[1]),
      .valid_o(valid[1]), .busy_o(busy[1]), .pending_o(pend[1]), .done_o(done[1]));

   h3_matrix_regenerator #(.REJECT_ZERO_ROWS(1'b0), .AUTO_COMMIT(1'b0)) u_c (
      .clk(clk), .reset(rst[2]), .regen_i(regen[2]), .commit_i(commit[2]),
      .seed_load_i(sload[2]), .seed_i(seed[2]), .matrixes_o(mat[2]),
      .valid_o(valid[2]), .busy_o(busy[2]), .pending_o(pend[2]), .done_o(done[2]));

   function automatic void model_run(input logic [31:0] seed_v, input bit rej,
                                     output logic [39:0] mv, output int cyc, output logic [31:0] fin);
      logic [31:0] s;
      logic [1:0]  c;
      int          row;
      s   = seed_v;
      mv  = '0;
      row = 0;
      cyc = 0;
      c   = '0;
      while (row < 20 && cyc < 1000) begin
         for (int k = 0; k < 2; k++) begin
            c[k] = s[0];
            s    = (s >> 1) ^ (s[0] ? TAPS_M : 32'h0);
         end
         cyc++;
         if (!(rej && c == 2'b00)) begin
            mv[row*2 +: 2] = c;
            row++;
         end
      end
      fin = s;
   endfunction

   function automatic int zero_rows(input logic [39:0] v);
      int z = 0;
      for (int r = 0; r < 20; r++) if (v[r*2 +: 2] == 2'b00) z++;
      return z;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_flag(input int d, input bit want_pend, input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(want_pend ? pend[d] : done[d]) && cyc < max);
   endtask

   task automatic start_regen(input int d, input bit load, input logic [31:0] s);
      regen[d] = 1'b1;
      sload[d] = load;
      seed[d]  = s;
      @(negedge clk);
      regen[d] = 1'b0;
      sload[d] = 1'b0;
      seed[d]  = '0;
      chk($sformatf("busy_after_regen_d%0d", d), busy[d], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [7];
      logic [31:0] st   [3];
      logic [39:0] m, m2, m4, mref;
      logic [31:0] f, f3, s, ms;
      int          c, cyc, cyc2, d;
      bit          found;

      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; regen[i] = 1'b0; commit[i] = 1'b0; sload[i] = 1'b0; seed[i] = '0;
         st[i] = SEED_M;
      end

      vecs[0] = '{0, 1'b1, 32'h0000_0000, 1'b1, 4'b1011};
      vecs[1] = '{0, 1'b0, 32'h0000_0000, 1'b0, 4'b0000};
      vecs[2] = '{0, 1'b1, 32'h1234_5678, 1'b1, 4'b1000};
      vecs[3] = '{0, 1'b1, 32'h0000_0001, 1'b1, 4'b1011};
      vecs[4] = '{1, 1'b1, 32'h1234_5678, 1'b1, 4'b1110};
      vecs[5] = '{1, 1'b1, 32'h0000_0000, 1'b1, 4'b1011};
      vecs[6] = '{1, 1'b0, 32'h0000_0000, 1'b0, 4'b0000};

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_mat_d%0d", i), mat[i], 0);
         chk($sformatf("rst_valid_d%0d", i), valid[i], 0);
         chk($sformatf("rst_busy_d%0d", i), busy[i], 1);
         chk($sformatf("rst_pend_d%0d", i), pend[i], 0);
         chk($sformatf("rst_done_d%0d", i), done[i], 0);
      end

      // initial run, no rejection
      rst[0] = 1'b0;
      wait_flag(0, 1'b0, 100, cyc);
      model_run(SEED_M, 1'b0, m, c, f);
      st[0] = f;
      chk("a_init_cycles", cyc, 20);
      chk("a_init_mat", mat[0], m);
      chk("a_init_row0", mat[0][1:0], 2'b11);
      chk("a_init_row1", mat[0][3:2], 2'b10);
      chk("a_init_valid", valid[0], 1);
      chk("a_init_busy", busy[0], 0);
      @(negedge clk);
      chk("a_init_done_pulse", done[0], 0);

      // initial run with rejection
      rst[1] = 1'b0;
      wait_flag(1, 1'b0, 100, cyc);
      model_run(SEED_M, 1'b1, m, c, f);
      st[1] = f;
      chk("b_init_cycles", cyc, c);
      chk("b_init_mat", mat[1], m);
      chk("b_init_zero_rows", zero_rows(mat[1]), 0);
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         d  = vecs[i].d;
         ms = vecs[i].load ? ((vecs[i].seed == 0) ? SEED_M : vecs[i].seed) : st[d];
         model_run(ms, d == 1, m, c, f);
         start_regen(d, vecs[i].load, vecs[i].seed);
         wait_flag(d, 1'b0, 200, cyc);
         chk($sformatf("vec%0d_cycles", i), cyc, c);
         chk($sformatf("vec%0d_mat", i), mat[d], m);
         if (vecs[i].use_lo) chk($sformatf("vec%0d_lo_rows", i), mat[d][3:0], vecs[i].lo);
         if (d == 1) chk($sformatf("vec%0d_zero_rows", i), zero_rows(mat[d]), 0);
         chk($sformatf("vec%0d_valid", i), valid[d], 1);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), done[d], 0);
         st[d] = f;
      end

      // seed giving exactly two rejected rows
      s = 32'h1234_5678;
      found = 1'b0;
      for (int n = 0; n < 4000 && !found; n++) begin
         model_run(s, 1'b1, m, c, f);
         if (c == 22) found = 1'b1;
         else s = s + 32'h1;
      end
      start_regen(1, 1'b1, s);
      wait_flag(1, 1'b0, 200, cyc);
      chk("rej2_cycles", cyc, 22);
      chk("rej2_mat", mat[1], m);
      chk("rej2_zero_rows", zero_rows(mat[1]), 0);
      @(negedge clk);

      // regen held through GEN, plus seed_load during GEN
      model_run(SEED_M, 1'b0, mref, c, f);
      regen[0] = 1'b1; sload[0] = 1'b1; seed[0] = 32'h0;
      @(negedge clk);
      sload[0] = 1'b0;
      repeat (5) @(negedge clk);
      sload[0] = 1'b1; seed[0] = 32'h1234_5678;
      @(negedge clk);
      sload[0] = 1'b0; seed[0] = 32'h0;
      wait_flag(0, 1'b0, 200, cyc);
      regen[0] = 1'b0;
      chk("held_cycles", cyc + 6, 20);
      chk("held_mat", mat[0], mref);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("held_no_restart_%0d", i), busy[0], 0);
         chk($sformatf("held_no_done_%0d", i), done[0], 0);
      end

      // manual commit mode
      rst[2] = 1'b0;
      wait_flag(2, 1'b0, 100, cyc);
      model_run(SEED_M, 1'b0, m, c, f);
      chk("c_init_cycles", cyc, 20);
      chk("c_init_mat", mat[2], m);
      chk("c_init_pend", pend[2], 0);
      @(negedge clk);
      commit[2] = 1'b1;
      @(negedge clk);
      commit[2] = 1'b0;
      chk("c_idle_commit_done", done[2], 0);
      chk("c_idle_commit_mat", mat[2], m);

      model_run(32'h1234_5678, 1'b0, m2, c, f);
      start_regen(2, 1'b1, 32'h1234_5678);
      wait_flag(2, 1'b1, 200, cyc);
      chk("c_pend_cycles", cyc, 20);
      chk("c_pend_busy", busy[2], 0);
      chk("c_pend_mat_held", mat[2], m);
      chk("c_pend_no_done", done[2], 0);
      repeat (3) @(negedge clk);
      chk("c_pend_stays", pend[2], 1);
      chk("c_pend_mat_still", mat[2], m);
      commit[2] = 1'b1;
      @(negedge clk);
      commit[2] = 1'b0;
      chk("c_commit_mat", mat[2], m2);
      chk("c_commit_done", done[2], 1);
      chk("c_commit_pend", pend[2], 0);
      @(negedge clk);
      chk("c_commit_done_pulse", done[2], 0);

      model_run(SEED_M, 1'b0, m, c, f3);
      start_regen(2, 1'b1, 32'h0);
      wait_flag(2, 1'b1, 200, cyc);
      chk("c_pend2_cycles", cyc, 20);
      regen[2] = 1'b1; commit[2] = 1'b1;
      @(negedge clk);
      regen[2] = 1'b0; commit[2] = 1'b0;
      chk("c_both_busy", busy[2], 1);
      chk("c_both_no_done", done[2], 0);
      chk("c_both_mat", mat[2], m2);
      model_run(f3, 1'b0, m4, c, f);
      wait_flag(2, 1'b1, 200, cyc2);
      chk("c_restart_cycles", cyc2, 20);
      commit[2] = 1'b1;
      @(negedge clk);
      commit[2] = 1'b0;
      chk("c_restart_mat", mat[2], m4);
      chk("c_restart_done", done[2], 1);

      // reset in the middle of a regen
      start_regen(0, 1'b1, 32'h1234_5678);
      repeat (10) @(negedge clk);
      rst[0] = 1'b1;
      #1;
      chk("midrst_mat", mat[0], 0);
      chk("midrst_valid", valid[0], 0);
      chk("midrst_busy", busy[0], 1);
      chk("midrst_pend", pend[0], 0);
      @(negedge clk);
      rst[0] = 1'b0;
      wait_flag(0, 1'b0, 100, cyc);
      chk("midrst_init_cycles", cyc, 20);
      chk("midrst_init_mat", mat[0], mref);
      chk("midrst_init_lo", mat[0][3:0], 4'b1011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
